// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART timing blocks.
// The optional fractional divisor is built in with UART_BAUD_FRAC_EN.
package uart_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int OSR_DEF   = 16;
  localparam int FRAC_W    = 4;

  typedef logic [DIV_W_DEF-1:0]       div_t;
  typedef logic [$clog2(OSR_DEF)-1:0] phase_t;

endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc: fractional divisor accumulator. Each tick adds F; a carry-out
// stretches the following oversample period by one clk. Built only with UART_BAUD_FRAC_EN.
`ifdef UART_BAUD_FRAC_EN
module uart_frac_acc
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              tick,
  input  logic [FRAC_W-1:0] frac,
  output logic              ext
);

  logic [FRAC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (tick) begin
      {ext, acc} <= {1'b0, acc} + {1'b0, frac};
    end
  end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample (os_tick) and bit (bit_tick) strobes from the baud divisor.
// Define UART_BAUD_FRAC_EN to use baud_div[DIV_W+3:DIV_W] as a 4-bit fractional divisor.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int OSR   = OSR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             baud_div,
  input  logic                    en,
  input  logic                    restart,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OSR)-1:0]  os_phase,
  output logic                    div_zero
);

  localparam int PW = $clog2(OSR);

  logic [DIV_W-1:0] div_new;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [PW-1:0]    phase;
  logic             os_q;
  logic             bit_q;
  logic             div_chg;
  logic             realign;
  logic             at_term;
  logic             fire;
  logic             ext;
  logic             unused_baud;

  assign div_new  = baud_div[DIV_W-1:0];
  assign div_zero = (div_new == '0);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_new;
  logic [FRAC_W-1:0] frac_q;

  assign frac_new    = baud_div[DIV_W+FRAC_W-1:DIV_W];
  assign unused_baud = ^baud_div[31:DIV_W+FRAC_W];
  assign div_chg     = (div_new != div_q) || (frac_new != frac_q);

  always_ff @(posedge clk) begin
    if (rst) frac_q <= '0;
    else     frac_q <= frac_new;
  end

  uart_frac_acc u_frac_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart || div_chg),
    .tick (fire),
    .frac (frac_q),
    .ext  (ext)
  );
`else
  assign unused_baud = ^baud_div[31:DIV_W];
  assign div_chg     = (div_new != div_q);
  assign ext         = 1'b0;
`endif

  // A stalled divisor (0) pins the counters at zero just like a realignment.
  assign realign = restart || div_chg || (div_q == '0);
  assign at_term = (div_cnt == div_q - DIV_W'(1) + DIV_W'(ext));
  assign fire    = !realign && en && at_term;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      div_cnt <= '0;
      phase   <= '0;
      os_q    <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      div_q <= div_new;
      os_q  <= fire;
      bit_q <= fire && (phase == PW'(OSR - 1));
      if (realign) begin
        div_cnt <= '0;
        phase   <= '0;
      end else if (fire) begin
        div_cnt <= '0;
        phase   <= phase + PW'(1);
      end else if (en) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign os_tick  = os_q;
  assign bit_tick = bit_q;
  assign os_phase = phase;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: vector table, directed corner sequences and random stimulus,
// all compared against a cumulative-boundary reference model.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int DIV_W = DIV_W_DEF;
  localparam int OSR   = OSR_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        restart;
  logic [31:0] baud_div;
  logic        os_tick;
  logic        bit_tick;
  logic        div_zero;
  phase_t      os_phase;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: active cycles since the last alignment and os_ticks seen since then.
  longint      m_elapsed = 0;
  longint      m_nt      = 0;
  logic [19:0] m_key     = '0;
  logic        m_os      = 1'b0;
  logic        m_bit     = 1'b0;

  typedef struct {
    logic        r;
    logic        e;
    logic        rs;
    logic [31:0] b;
    logic        os;
    logic        bt;
    logic [3:0]  ph;
    logic        dz;
  } vec_t;

  uart_baud_gen #(.DIV_W(DIV_W), .OSR(OSR)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .en       (en),
    .restart  (restart),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] key_of(input logic [31:0] b);
`ifdef UART_BAUD_FRAC_EN
    return b[19:0];
`else
    return {4'h0, b[15:0]};
`endif
  endfunction

  // Clk cycles from alignment to the n-th os_tick: n*DIV plus one per fractional carry.
  function automatic longint span(input longint n, input longint d, input longint f);
    return (n == 0) ? 0 : n * d + ((n - 1) * f) / 16;
  endfunction

  task automatic model_step();
    logic [19:0] k;
    longint      d;
    longint      f;
    m_os  = 1'b0;
    m_bit = 1'b0;
    if (rst) begin
      m_key     = '0;
      m_elapsed = 0;
      m_nt      = 0;
      return;
    end
    k = key_of(baud_div);
    d = longint'(k[15:0]);
    f = longint'(k[19:16]);
    if (restart || (k != m_key) || (d == 0)) begin
      m_elapsed = 0;
      m_nt      = 0;
    end else if (en) begin
      m_elapsed++;
      if (m_elapsed == span(m_nt + 1, d, f)) begin
        m_nt++;
        m_os  = 1'b1;
        m_bit = ((m_nt % OSR) == 0);
      end
    end
    m_key = k;
  endtask

  task automatic step(input logic r, input logic e, input logic rs, input logic [31:0] b);
    rst      = r;
    en       = e;
    restart  = rs;
    baud_div = b;
    model_step();
    @(posedge clk);
    #1;
    check("model_os_tick",  32'(os_tick),  32'(m_os));
    check("model_bit_tick", 32'(bit_tick), 32'(m_bit));
    check("model_os_phase", 32'(os_phase), 32'(m_nt % OSR));
    check("model_div_zero", 32'(div_zero), 32'(b[15:0] == 16'd0));
  endtask

  initial begin
    vec_t        tbl[20];
    int          last_os;
    int          last_bit;
    int          prev_ph;
    int          n_os;
    logic [31:0] b;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd4,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd4,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd4,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd4,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd4,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd4,          1'b1, 1'b0, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'd1,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'd1,          1'b1, 1'b0, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd1,          1'b1, 1'b0, 4'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b0, 1'b0, 4'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b0, 1'b0, 4'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0001_0000,  1'b0, 1'b0, 4'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'd2,          1'b1, 1'b0, 4'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 32'd2,          1'b1, 1'b0, 4'd1, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 32'd2,          1'b0, 1'b0, 4'd0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].rs, tbl[i].b);
      check($sformatf("tbl%0d_os", i),  32'(os_tick),  32'(tbl[i].os));
      check($sformatf("tbl%0d_bit", i), 32'(bit_tick), 32'(tbl[i].bt));
      check($sformatf("tbl%0d_ph", i),  32'(os_phase), 32'(tbl[i].ph));
      check($sformatf("tbl%0d_dz", i),  32'(div_zero), 32'(tbl[i].dz));
    end

    // DIV=4: os_tick every 4 clks, bit_tick every 64, phase steps 0..15.
    step(1'b1, 1'b1, 1'b0, 32'd4);
    last_os  = -1;
    last_bit = -1;
    prev_ph  = 0;
    n_os     = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'd4);
      if (os_tick) begin
        n_os++;
        if (last_os >= 0) check("t1_os_gap", 32'(c - last_os), 32'd4);
        check("t1_phase", 32'(os_phase), 32'((prev_ph + 1) % 16));
        prev_ph = int'(os_phase);
        last_os = c;
      end
      if (bit_tick) begin
        if (last_bit >= 0) check("t1_bit_gap", 32'(c - last_bit), 32'd64);
        last_bit = c;
      end
    end
    check("t1_os_count", 32'(n_os), 32'd49);

    // DIV=10 -> DIV=3 written at div_cnt=7.
    step(1'b1, 1'b1, 1'b0, 32'd10);
    step(1'b0, 1'b1, 1'b0, 32'd10);
    repeat (27) step(1'b0, 1'b1, 1'b0, 32'd10);
    check("t3_pre_phase", 32'(os_phase), 32'd2);
    step(1'b0, 1'b1, 1'b0, 32'd3);
    check("t3_write_os", 32'(os_tick), 32'd0);
    check("t3_write_phase", 32'(os_phase), 32'd0);
    repeat (2) begin
      step(1'b0, 1'b1, 1'b0, 32'd3);
      check("t3_wait_os", 32'(os_tick), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 32'd3);
    check("t3_first_os", 32'(os_tick), 32'd1);
    check("t3_first_phase", 32'(os_phase), 32'd1);

    // restart at phase 9 coinciding with the terminal count.
    step(1'b1, 1'b1, 1'b0, 32'd4);
    step(1'b0, 1'b1, 1'b0, 32'd4);
    repeat (39) step(1'b0, 1'b1, 1'b0, 32'd4);
    check("t4_pre_phase", 32'(os_phase), 32'd9);
    step(1'b0, 1'b1, 1'b1, 32'd4);
    check("t4_restart_os", 32'(os_tick), 32'd0);
    check("t4_restart_phase", 32'(os_phase), 32'd0);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, 32'd4);
      check("t4_wait_os", 32'(os_tick), 32'd0);
      check("t4_wait_phase", 32'(os_phase), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 32'd4);
    check("t4_first_os", 32'(os_tick), 32'd1);
    check("t4_first_phase", 32'(os_phase), 32'd1);

    // en low for 5 clks at DIV=8 with div_cnt=3.
    step(1'b1, 1'b1, 1'b0, 32'd8);
    step(1'b0, 1'b1, 1'b0, 32'd8);
    repeat (11) step(1'b0, 1'b1, 1'b0, 32'd8);
    repeat (5) begin
      step(1'b0, 1'b0, 1'b0, 32'd8);
      check("t5_hold_os", 32'(os_tick), 32'd0);
      check("t5_hold_phase", 32'(os_phase), 32'd1);
    end
    repeat (4) begin
      step(1'b0, 1'b1, 1'b0, 32'd8);
      check("t5_resume_os", 32'(os_tick), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 32'd8);
    check("t5_resume_tick", 32'(os_tick), 32'd1);
    check("t5_resume_phase", 32'(os_phase), 32'd2);

`ifdef UART_BAUD_FRAC_EN
    begin
      int ticks[17];
      int nt;
      nt = 0;
      step(1'b1, 1'b1, 1'b0, 32'h0008_0004);
      for (int c = 0; c < 100; c++) begin
        step(1'b0, 1'b1, 1'b0, 32'h0008_0004);
        if (os_tick && nt < 17) begin
          ticks[nt] = c;
          nt++;
        end
      end
      check("t6_tick_count", 32'(nt), 32'd17);
      if (nt == 17) begin
        check("t6_span", 32'(ticks[16] - ticks[0]), 32'd72);
        for (int i = 1; i < 17; i++)
          check($sformatf("t6_gap%0d", i), 32'(ticks[i] - ticks[i-1]), (i % 2 == 1) ? 32'd4 : 32'd5);
      end
    end
`endif

    // Random traffic against the reference model.
    b = 32'd3;
    step(1'b1, 1'b1, 1'b0, b);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) == 0)
        b = ($urandom() & 32'hFFF0_0000) | (32'($urandom_range(15)) << 16) | 32'($urandom_range(6));
      else if ($urandom_range(99) == 0)
        b = b ^ ($urandom() & 32'hFFF0_0000);
      step($urandom_range(299) == 0, $urandom_range(9) != 0, $urandom_range(49) == 0, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
